// File: rtl/demux_collector_pkg.sv
// demux_collector_pkg: shared word width, index-width helper and default sizes for the serial word collector
package demux_collector_pkg;
  localparam int DATA_W = 4;
  function automatic int idx_w(input int w);
    return $clog2(w);
  endfunction
  localparam int DEF_IDX_W = idx_w(DATA_W);
endpackage

// File: rtl/demux_collector_if.sv
// demux_collector_if: collector bundle; master drives din/din_valid/clear/dout_ready, slave returns din_ready/dout/dout_valid/bit_idx
interface demux_collector_if import demux_collector_pkg::*; #(
  parameter int WIDTH = DATA_W,
  parameter int IDX_W = idx_w(WIDTH)
);
  logic             clear;
  logic             din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [IDX_W-1:0] bit_idx;
  modport master(output clear, din, din_valid, dout_ready, input din_ready, dout, dout_valid, bit_idx);
  modport slave(input clear, din, din_valid, dout_ready, output din_ready, dout, dout_valid, bit_idx);
endinterface

// File: rtl/demux_collector_bit_demux.sv
// demux_collector_bit_demux: one-hot write-enable decode (we) of idx gated by en, combinational
module demux_collector_bit_demux import demux_collector_pkg::*; #(
  parameter int WIDTH = DATA_W,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [WIDTH-1:0] we
);
  always_comb we = en ? (WIDTH'(1) << idx) : '0;
endmodule

// File: rtl/demux_collector.sv
// demux_collector: bit-serial to WIDTH-bit word collector (LSB first); ports clk, rst_n (async low), bus (slave: din/din_valid/din_ready in, dout/dout_valid/dout_ready out, clear, bit_idx)
module demux_collector import demux_collector_pkg::*; #(
  parameter int WIDTH = DATA_W,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input logic              clk,
  input logic              rst_n,
  demux_collector_if.slave bus
);
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] asm_q, asm_d, dout_q, dout_d, we;
  logic             dout_valid_q, dout_valid_d;
  logic             last, din_ready, take, done;
  assign last      = bit_idx_q == IDX_W'(WIDTH - 1);
  assign din_ready = !(last && dout_valid_q && !bus.dout_ready);
  assign take      = bus.din_valid && din_ready && !bus.clear;
  assign done      = take && last;
  demux_collector_bit_demux #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_demux (
    .idx(bit_idx_q),
    .en (take),
    .we (we)
  );
  always_comb begin
    bit_idx_d    = (bus.clear || done) ? '0 : take ? bit_idx_q + 1'b1 : bit_idx_q;
    asm_d        = (bus.clear || done) ? '0 : (asm_q & ~we) | ({WIDTH{bus.din}} & we);
    dout_d       = done ? {bus.din, asm_q[WIDTH-2:0]} : dout_q;
    dout_valid_d = done || (dout_valid_q && !bus.dout_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx_q    <= '0;
      asm_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      bit_idx_q    <= bit_idx_d;
      asm_q        <= asm_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end
  assign bus.din_ready  = din_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.bit_idx    = bit_idx_q;
endmodule

// File: tb/tb_demux_collector.sv
// tb_demux_collector: directed and scoreboard-checked stimulus for demux_collector
module tb_demux_collector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  demux_collector_if #(.WIDTH(4), .IDX_W(2)) bus ();
  demux_collector #(.WIDTH(4), .IDX_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_in(input logic v, input logic d, input logic r, input logic c);
    bus.din_valid  = v;
    bus.din        = d;
    bus.dout_ready = r;
    bus.clear      = c;
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  initial begin
    logic [3:0] w;
    logic [6:0] vpat;
    logic [3:0] q[$];
    logic [3:0] m_part;
    logic [1:0] m_idx;
    logic v, d, r, m_vld, exp_rdy;
    int k, popped;
    set_in(0, 0, 0, 0);
    repeat (2) tick;
    chk("rst_idx", bus.bit_idx, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_vld", bus.dout_valid, 0);
    chk("rst_rdy", bus.din_ready, 1);
    rst_n = 1'b1;
    tick;
    w = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      set_in(1, w[i], 1, 0);
      #1;
      chk("t1_idx", bus.bit_idx, i);
      chk("t1_vld_lo", bus.dout_valid, 0);
      tick;
    end
    chk("t1_dout", bus.dout, 4'b1101);
    chk("t1_vld", bus.dout_valid, 1);
    chk("t1_idx_wrap", bus.bit_idx, 0);
    set_in(0, 0, 1, 0);
    tick;
    chk("t1_vld_one", bus.dout_valid, 0);
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 0, 0);
      tick;
    end
    chk("t2_w1", bus.dout, 4'b1111);
    chk("t2_vld1", bus.dout_valid, 1);
    w = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      set_in(1, w[i], 0, 0);
      #1;
      chk("t2_rdy_full", bus.din_ready, 1);
      tick;
    end
    chk("t2_idx3", bus.bit_idx, 3);
    chk("t2_hold", bus.dout, 4'b1111);
    set_in(1, w[3], 0, 0);
    #1;
    chk("t2_stall", bus.din_ready, 0);
    tick;
    chk("t2_idx_stall", bus.bit_idx, 3);
    chk("t2_hold2", bus.dout, 4'b1111);
    chk("t2_vld_hold", bus.dout_valid, 1);
    set_in(1, w[3], 1, 0);
    #1;
    chk("t2_rdy_thru", bus.din_ready, 1);
    tick;
    chk("t2_w2", bus.dout, 4'b0010);
    chk("t2_vld2", bus.dout_valid, 1);
    chk("t2_idx0", bus.bit_idx, 0);
    set_in(0, 0, 1, 0);
    tick;
    chk("t2_drain", bus.dout_valid, 0);
    vpat = 7'b1101001;
    w = 4'b0110;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      set_in(vpat[i], vpat[i] ? w[k] : 1'b1, 1, 0);
      tick;
      if (vpat[i]) k++;
      chk("t3_idx", bus.bit_idx, k % 4);
    end
    chk("t3_dout", bus.dout, 4'b0110);
    chk("t3_vld", bus.dout_valid, 1);
    set_in(1, 1, 1, 0);
    tick;
    tick;
    chk("t4_idx2", bus.bit_idx, 2);
    set_in(0, 0, 1, 1);
    tick;
    chk("t4_clr_idx", bus.bit_idx, 0);
    w = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      set_in(1, w[i], 1, 0);
      tick;
    end
    chk("t4_dout", bus.dout, 4'b0100);
    chk("t4_vld", bus.dout_valid, 1);
    set_in(1, 1, 1, 1);
    #1;
    chk("t4_clr_rdy", bus.din_ready, 1);
    tick;
    chk("t4_drop_idx", bus.bit_idx, 0);
    chk("t4_clr_drain", bus.dout_valid, 0);
    chk("t4_dout_keep", bus.dout, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 0, 0);
      tick;
    end
    set_in(1, 1, 0, 0);
    tick;
    set_in(1, 0, 0, 0);
    tick;
    chk("t5_pre_idx", bus.bit_idx, 2);
    chk("t5_pre_vld", bus.dout_valid, 1);
    set_in(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", bus.dout_valid, 0);
    chk("t5_rst_dout", bus.dout, 0);
    chk("t5_rst_idx", bus.bit_idx, 0);
    #1 rst_n = 1'b1;
    tick;
    w = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      set_in(1, w[i], 1, 0);
      tick;
    end
    chk("t5_dout", bus.dout, 4'b1110);
    chk("t5_vld", bus.dout_valid, 1);
    set_in(0, 0, 1, 0);
    tick;
    m_idx = 0;
    m_part = 0;
    popped = 0;
    for (int n = 0; n < 10000; n++) begin
      v = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      set_in(v, d, r, 0);
      #1;
      m_vld = q.size() > 0;
      exp_rdy = !(m_idx == 2'd3 && m_vld && !r);
      chk("rnd_rdy", bus.din_ready, exp_rdy);
      chk("rnd_vld", bus.dout_valid, m_vld);
      chk("rnd_idx", bus.bit_idx, m_idx);
      if (m_vld) chk("rnd_dout", bus.dout, q[0]);
      tick;
      if (m_vld && r) begin
        void'(q.pop_front());
        popped++;
      end
      if (v && exp_rdy) begin
        m_part[m_idx] = d;
        if (m_idx == 2'd3) begin
          q.push_back(m_part);
          m_part = 0;
        end
        m_idx = m_idx + 2'd1;
      end
    end
    chk("rnd_words", popped > 500, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
